// File: rtl/viterbi_dec_if.sv
// Symbol/control bundle for the Viterbi decoder.
// master: symbol source and mask/clear control; slave: the decoder.
interface viterbi_dec_if #(
  parameter int N = 4
);
  logic [1:0]   load_mask;
  logic [N-1:0] mask;
  logic         clear;
  logic [1:0]   sym_in;
  logic         sym_valid;
  logic         data_out;
  logic         out_valid;

  modport master (
    output load_mask, mask, clear,
    output sym_in, sym_valid,
    input  data_out, out_valid
  );

  modport slave (
    input  load_mask, mask, clear,
    input  sym_in, sym_valid,
    output data_out, out_valid
  );
endinterface

// File: rtl/viterbi_dec.sv
// Hard-decision rate-1/2 Viterbi decoder, register-exchange survivors.
// Ports: clk, reset (async high), bus (slave: masks, clear, symbols, decoded bit).
module viterbi_dec #(
  parameter int           N          = 4,
  parameter int           DEPTH      = 16,
  parameter int           PMW        = 8,
  parameter logic [N-1:0] MASK0_INIT = N'(4'b1111),
  parameter logic [N-1:0] MASK1_INIT = N'(4'b1011)
) (
  input logic         clk,
  input logic         reset,
  viterbi_dec_if.slave bus
);

  localparam int NS = 1 << (N - 1);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  // Non-zero states start far behind: the encoder begins in state 0.
  localparam logic [PMW-1:0] PM_INIT =
    {2'b01, {(PMW - 2){1'b0}}};

  logic [N-1:0]     mask0;
  logic [N-1:0]     mask1;
  logic [PMW-1:0]   pm       [NS];
  logic [DEPTH-1:0] surv     [NS];
  logic [FW-1:0]    fill;
  logic             data_q;
  logic             valid_q;

  logic [PMW-1:0]   pm_acs   [NS];
  logic [PMW-1:0]   pm_nxt   [NS];
  logic [DEPTH-1:0] surv_nxt [NS];
  logic [FW-1:0]    fill_nxt;
  logic             all_msb;
  logic [N-2:0]     best;
  logic [PMW-1:0]   best_pm;
  logic [PMW-1:0]   best_df;

  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;

  function automatic logic [1:0] hamm(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  always_comb begin
    all_msb = 1'b1;
    for (int t = 0; t < NS; t++) begin : acs
      logic [N-2:0]   tt;
      logic [N-2:0]   s0;
      logic [N-2:0]   s1;
      logic [N-1:0]   r0;
      logic [N-1:0]   r1;
      logic [1:0]     e0;
      logic [1:0]     e1;
      logic [PMW-1:0] c0;
      logic [PMW-1:0] c1;
      logic [PMW-1:0] df;
      logic           sel;
      tt  = (N - 1)'(t);
      s0  = {tt[N-3:0], 1'b0};
      s1  = {tt[N-3:0], 1'b1};
      r0  = {tt[N-2], s0};
      r1  = {tt[N-2], s1};
      e0  = {^(mask1 & r0), ^(mask0 & r0)};
      e1  = {^(mask1 & r1), ^(mask0 & r1)};
      c0  = pm[s0] + PMW'(hamm(bus.sym_in, e0));
      c1  = pm[s1] + PMW'(hamm(bus.sym_in, e1));
      // Modular compare: c1 < c0 iff the wrapped difference is negative.
      df  = c1 - c0;
      sel = df[PMW-1];
      pm_acs[t] = sel ? c1 : c0;
      surv_nxt[t] = sel ?
        {surv[s1][DEPTH-2:0], tt[N-2]} :
        {surv[s0][DEPTH-2:0], tt[N-2]};
      all_msb = all_msb & pm_acs[t][PMW-1];
    end

    for (int t = 0; t < NS; t++) begin
      pm_nxt[t] = pm_acs[t];
      if (all_msb) pm_nxt[t][PMW-1] = 1'b0;
    end

    best    = '0;
    best_pm = pm_nxt[0];
    best_df = '0;
    for (int t = 1; t < NS; t++) begin
      best_df = pm_nxt[t] - best_pm;
      if (best_df[PMW-1]) begin
        best    = (N - 1)'(t);
        best_pm = pm_nxt[t];
      end
    end

    fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask0   <= MASK0_INIT;
      mask1   <= MASK1_INIT;
      for (int i = 0; i < NS; i++) begin
        pm[i]   <= (i == 0) ? '0 : PM_INIT;
        surv[i] <= '0;
      end
      fill    <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (bus.load_mask[0]) mask0 <= bus.mask;
      if (bus.load_mask[1]) mask1 <= bus.mask;
      if (bus.clear) begin
        for (int i = 0; i < NS; i++) begin
          pm[i]   <= (i == 0) ? '0 : PM_INIT;
          surv[i] <= '0;
        end
        fill    <= '0;
        data_q  <= 1'b0;
        valid_q <= 1'b0;
      end else if (bus.sym_valid) begin
        for (int i = 0; i < NS; i++) begin
          pm[i]   <= pm_nxt[i];
          surv[i] <= surv_nxt[i];
        end
        fill    <= fill_nxt;
        data_q  <= surv_nxt[best][DEPTH-1];
        valid_q <= (fill_nxt == FULL);
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_viterbi_dec.sv
// Directed bench for viterbi_dec: encoder model drives symbols,
// decoded stream is compared against the bits that were sent.
module tb_viterbi_dec;

  logic clk = 1'b0;
  logic reset;

  viterbi_dec_if #(.N(4)) bus ();

  viterbi_dec #(
    .N(4), .DEPTH(16), .PMW(8),
    .MASK0_INIT(4'b1111), .MASK1_INIT(4'b1011)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_n  = 0;
  int total_n = 0;
  int acc;
  int first_v;
  int sc;
  logic [3:0] tm0;
  logic [3:0] tm1;
  logic [2:0] st;
  bit outq[$];
  bit sent[$];

  task automatic chk(input string tag, input int got, input int exp);
    total_n++;
    if (got == exp) pass_n++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  task automatic restart();
    acc = 0;
    first_v = 0;
    st = '0;
    outq.delete();
    sent.delete();
  endtask

  task automatic drive(input bit v, input logic [1:0] s,
                       input logic [1:0] lm, input logic [3:0] mk,
                       input bit clr);
    bus.sym_valid = v;
    bus.sym_in    = s;
    bus.load_mask = lm;
    bus.mask      = mk;
    bus.clear     = clr;
    @(posedge clk);
    #1;
    if (v && !clr) acc++;
    if (bus.out_valid) begin
      if (first_v == 0) first_v = acc;
      outq.push_back(bus.data_out);
    end
    bus.sym_valid = 1'b0;
    bus.load_mask = 2'b00;
    bus.clear     = 1'b0;
  endtask

  task automatic enc(input bit b, input logic [1:0] flip,
                     input logic [1:0] lm, input logic [3:0] mk);
    logic [3:0] r;
    logic [1:0] s;
    r = {b, st};
    s = {^(tm1 & r), ^(tm0 & r)} ^ flip;
    drive(1'b1, s, lm, mk, 1'b0);
    if (lm[0]) tm0 = mk;
    if (lm[1]) tm1 = mk;
    st = {b, st[2:1]};
    sent.push_back(b);
  endtask

  task automatic cmp_stream(input string tag, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < outq.size() && i < n; i++)
      if (outq[i] != sent[i]) errs++;
    chk({tag, "_count"}, outq.size(), n);
    chk({tag, "_errs"}, errs, 0);
  endtask

  task automatic do_clear();
    drive(1'b0, 2'b00, 2'b00, 4'h0, 1'b1);
    restart();
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tm0 = 4'b1111;
    tm1 = 4'b1011;
    restart();
  endtask

  function automatic int ones();
    int n;
    n = 0;
    foreach (outq[i]) n += outq[i];
    return n;
  endfunction

  logic [1:0] t2 [4] = '{2'b11, 2'b01, 2'b11, 2'b11};
  bit last;

  initial begin
    bus.sym_valid = 1'b0;
    bus.sym_in    = 2'b00;
    bus.load_mask = 2'b00;
    bus.mask      = 4'h0;
    bus.clear     = 1'b0;
    tm0 = 4'b1111;
    tm1 = 4'b1011;
    restart();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_data_out", bus.data_out, 0);
    reset = 1'b0;

    // All-zero stream
    repeat (40) drive(1'b1, 2'b00, 2'b00, 4'h0, 1'b0);
    chk("t1_first_valid", first_v, 16);
    chk("t1_count", outq.size(), 25);
    chk("t1_ones", ones(), 0);

    // Single 1 then zeros, clean channel
    do_clear();
    foreach (t2[i]) drive(1'b1, t2[i], 2'b00, 4'h0, 1'b0);
    repeat (36) drive(1'b1, 2'b00, 2'b00, 4'h0, 1'b0);
    chk("t2_count", outq.size(), 25);
    chk("t2_bit0", outq[0], 1);
    chk("t2_ones", ones(), 1);
    last = bus.data_out;
    drive(1'b0, 2'b11, 2'b00, 4'h0, 1'b0);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_data_hold", bus.data_out, last);

    // Same stream with symbol 2 corrupted
    do_clear();
    t2[1] = 2'b00;
    foreach (t2[i]) drive(1'b1, t2[i], 2'b00, 4'h0, 1'b0);
    repeat (36) drive(1'b1, 2'b00, 2'b00, 4'h0, 1'b0);
    chk("t3_count", outq.size(), 25);
    chk("t3_bit0", outq[0], 1);
    chk("t3_ones", ones(), 1);

    // Mask reload while idle and on symbol edges
    do_clear();
    drive(1'b0, 2'b00, 2'b01, 4'b1101, 1'b0);
    tm0 = 4'b1101;
    drive(1'b0, 2'b00, 2'b10, 4'b1011, 1'b0);
    tm1 = 4'b1011;
    for (int i = 0; i < 100; i++) begin
      if (i >= 40 && i < 60)
        enc(1'($urandom_range(1)), 2'b00, 2'b10,
            (i % 2 == 0) ? 4'b1111 : 4'b1011);
      else
        enc(1'($urandom_range(1)), 2'b00, 2'b00, 4'h0);
    end
    repeat (15) enc(1'b0, 2'b00, 2'b00, 4'h0);
    cmp_stream("t4", 100);

    // Long noisy stream with random gaps
    hard_reset();
    sc = 0;
    for (int i = 0; i < 2000; i++) begin
      while ($urandom_range(1) == 1)
        drive(1'b0, 2'($urandom_range(3)), 2'b00, 4'h0, 1'b0);
      enc(1'($urandom_range(1)),
          (sc % 25 == 12) ?
            (($urandom_range(1) == 1) ? 2'b10 : 2'b01) : 2'b00,
          2'b00, 4'h0);
      sc++;
    end
    repeat (15) enc(1'b0, 2'b00, 2'b00, 4'h0);
    cmp_stream("t5", 2000);

    // Async reset mid-stream, then clear restart with kept masks
    do_clear();
    drive(1'b0, 2'b00, 2'b01, 4'b1101, 1'b0);
    tm0 = 4'b1101;
    repeat (30) enc(1'($urandom_range(1)), 2'b00, 2'b00, 4'h0);
    chk("t6_ov_pre", bus.out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_ov_async", bus.out_valid, 0);
    chk("t6_do_async", bus.data_out, 0);
    #1;
    reset = 1'b0;
    tm0 = 4'b1111;
    tm1 = 4'b1011;
    restart();
    repeat (20) enc(1'($urandom_range(1)), 2'b00, 2'b00, 4'h0);
    chk("t6_first_valid", first_v, 16);
    cmp_stream("t6a", 5);
    drive(1'b0, 2'b00, 2'b01, 4'b1101, 1'b0);
    tm0 = 4'b1101;
    drive(1'b1, 2'b11, 2'b00, 4'h0, 1'b1);
    restart();
    repeat (40) enc(1'($urandom_range(1)), 2'b00, 2'b00, 4'h0);
    repeat (15) enc(1'b0, 2'b00, 2'b00, 4'h0);
    chk("t6_clr_first_valid", first_v, 16);
    cmp_stream("t6b", 40);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
